// File: rtl/sgm_frame_sequencer_if.sv
// Stereo pixel input stream into the SGM frame sequencer.
// The source drives valid/pixels/markers and the sequencer returns ready.
interface sgm_frame_sequencer_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_left;
    logic [7:0] in_right;
    logic       in_sof;
    logic       in_eol;

    modport master (output in_valid, in_left, in_right, in_sof, in_eol, input in_ready);
    modport slave  (input in_valid, in_left, in_right, in_sof, in_eol, output in_ready);
endinterface

// File: rtl/sgm_frame_sequencer.sv
// Frame sequencer for the 2-path SGM core: core reset, SOF alignment, framing check,
// output x/y tagging and drain. Define SGM_SEQ_AUTO_RESTART_EN for continuous frames.
module sgm_frame_sequencer #(
    parameter int FRAME_WIDTH  = 272,
    parameter int FRAME_HEIGHT = 240
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    sgm_frame_sequencer_if.slave s_in,
    output logic                 core_rst,
    output logic [7:0]           core_left,
    output logic [7:0]           core_right,
    output logic                 core_pixel_valid,
    input  logic [5:0]           core_disparity,
    input  logic                 core_valid_out,
    output logic                 out_valid,
    output logic [5:0]           out_disparity,
    output logic [8:0]           out_x,
    output logic [8:0]           out_y,
    output logic                 out_sof,
    output logic                 out_eol,
    output logic                 err_sync,
    output logic [15:0]          frame_count
);
    typedef enum logic [2:0] {IDLE, CLEAR, WAIT_SOF, STREAM, DRAIN, DONE} state_t;

    localparam logic [8:0] X_LAST = 9'(FRAME_WIDTH - 1);
    localparam logic [8:0] Y_LAST = 9'(FRAME_HEIGHT - 1);

    state_t      state_q, state_d;
    logic [8:0]  in_x_q, in_x_d, in_y_q, in_y_d;
    logic [8:0]  ox_q, ox_d, oy_q, oy_d;
    logic        out_all_q, out_all_d;
    logic        busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic [15:0] frame_count_q, frame_count_d;
    logic [7:0]  core_left_q, core_left_d, core_right_q, core_right_d;
    logic        core_pv_q, core_pv_d;
    logic        out_valid_q, out_valid_d, out_sof_q, out_sof_d, out_eol_q, out_eol_d;
    logic [5:0]  out_disp_q, out_disp_d;
    logic [8:0]  out_x_q, out_x_d, out_y_q, out_y_d;

    logic in_ready_c, accept, at_eol, candidate, framing_bad, fwd, bad;

    assign in_ready_c  = (state_q == WAIT_SOF) || (state_q == STREAM);
    assign accept      = s_in.in_valid & in_ready_c;
    assign at_eol      = (in_x_q == X_LAST);
    // In WAIT_SOF only the SOF beat is a frame candidate; everything else is dropped silently.
    assign candidate   = accept && ((state_q == STREAM) || s_in.in_sof);
    assign framing_bad = (s_in.in_eol != at_eol) || ((state_q == STREAM) && s_in.in_sof);
    assign fwd         = candidate && !framing_bad;
    assign bad         = candidate && framing_bad;

    always_comb begin
        state_d       = state_q;
        in_x_d        = in_x_q;
        in_y_d        = in_y_q;
        ox_d          = ox_q;
        oy_d          = oy_q;
        out_all_d     = out_all_q;
        err_d         = err_q;
        frame_count_d = frame_count_q;
        done_d        = 1'b0;
        core_pv_d     = fwd;
        core_left_d   = fwd ? s_in.in_left  : core_left_q;
        core_right_d  = fwd ? s_in.in_right : core_right_q;
        out_valid_d   = core_valid_out;
        out_disp_d    = out_disp_q;
        out_x_d       = out_x_q;
        out_y_d       = out_y_q;
        out_sof_d     = 1'b0;
        out_eol_d     = 1'b0;

        if (core_valid_out) begin
            out_disp_d = core_disparity;
            out_x_d    = ox_q;
            out_y_d    = oy_q;
            out_sof_d  = (ox_q == 9'd0) && (oy_q == 9'd0);
            out_eol_d  = (ox_q == X_LAST);
            if (ox_q == X_LAST) begin
                ox_d = 9'd0;
                oy_d = (oy_q == Y_LAST) ? 9'd0 : oy_q + 9'd1;
                if (oy_q == Y_LAST) out_all_d = 1'b1;
            end else begin
                ox_d = ox_q + 9'd1;
            end
        end

        case (state_q)
            IDLE: if (start) state_d = CLEAR;
            CLEAR: begin
                in_x_d    = 9'd0;
                in_y_d    = 9'd0;
                ox_d      = 9'd0;
                oy_d      = 9'd0;
                out_all_d = 1'b0;
                state_d   = WAIT_SOF;
            end
            WAIT_SOF, STREAM: begin
                if (bad) begin
                    err_d   = 1'b1;
                    state_d = CLEAR;
                end else if (fwd) begin
                    state_d = STREAM;
                    if (at_eol) begin
                        in_x_d = 9'd0;
                        in_y_d = (in_y_q == Y_LAST) ? 9'd0 : in_y_q + 9'd1;
                        if (in_y_q == Y_LAST) state_d = DRAIN;
                    end else begin
                        in_x_d = in_x_q + 9'd1;
                    end
                end
            end
            DRAIN: if (out_all_q) begin
                state_d       = DONE;
                done_d        = 1'b1;
                frame_count_d = frame_count_q + 16'd1;
            end
`ifdef SGM_SEQ_AUTO_RESTART_EN
            DONE: state_d = CLEAR;
`else
            DONE: state_d = IDLE;
`endif
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            in_x_q        <= '0;
            in_y_q        <= '0;
            ox_q          <= '0;
            oy_q          <= '0;
            out_all_q     <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
            frame_count_q <= '0;
            core_left_q   <= '0;
            core_right_q  <= '0;
            core_pv_q     <= 1'b0;
            out_valid_q   <= 1'b0;
            out_disp_q    <= '0;
            out_x_q       <= '0;
            out_y_q       <= '0;
            out_sof_q     <= 1'b0;
            out_eol_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            in_x_q        <= in_x_d;
            in_y_q        <= in_y_d;
            ox_q          <= ox_d;
            oy_q          <= oy_d;
            out_all_q     <= out_all_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            err_q         <= err_d;
            frame_count_q <= frame_count_d;
            core_left_q   <= core_left_d;
            core_right_q  <= core_right_d;
            core_pv_q     <= core_pv_d;
            out_valid_q   <= out_valid_d;
            out_disp_q    <= out_disp_d;
            out_x_q       <= out_x_d;
            out_y_q       <= out_y_d;
            out_sof_q     <= out_sof_d;
            out_eol_q     <= out_eol_d;
        end
    end

    assign s_in.in_ready    = in_ready_c;
    assign core_rst         = rst | (state_q == CLEAR);
    assign busy             = busy_q;
    assign done             = done_q;
    assign err_sync         = err_q;
    assign frame_count      = frame_count_q;
    assign core_left        = core_left_q;
    assign core_right       = core_right_q;
    assign core_pixel_valid = core_pv_q;
    assign out_valid        = out_valid_q;
    assign out_disparity    = out_disp_q;
    assign out_x            = out_x_q;
    assign out_y            = out_y_q;
    assign out_sof          = out_sof_q;
    assign out_eol          = out_eol_q;
endmodule

// File: tb/tb_sgm_frame_sequencer.sv
// Directed/randomised bench for sgm_frame_sequencer on a 4x3 frame with a 1-cycle core stub.
module tb_sgm_frame_sequencer;
    localparam int W = 4;
    localparam int H = 3;
`ifdef SGM_SEQ_AUTO_RESTART_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    typedef struct packed { logic [7:0] l; logic [7:0] r; logic sof; logic eol; } beat_t;

    logic clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic busy, done, core_rst, core_pixel_valid, out_valid, out_sof, out_eol, err_sync;
    logic [7:0] core_left, core_right;
    logic [5:0] core_disparity, out_disparity;
    logic core_valid_out;
    logic [8:0] out_x, out_y;
    logic [15:0] frame_count;

    sgm_frame_sequencer_if sif ();

    sgm_frame_sequencer #(.FRAME_WIDTH(W), .FRAME_HEIGHT(H)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .s_in(sif.slave),
        .core_rst(core_rst), .core_left(core_left), .core_right(core_right),
        .core_pixel_valid(core_pixel_valid), .core_disparity(core_disparity),
        .core_valid_out(core_valid_out), .out_valid(out_valid), .out_disparity(out_disparity),
        .out_x(out_x), .out_y(out_y), .out_sof(out_sof), .out_eol(out_eol),
        .err_sync(err_sync), .frame_count(frame_count));

    always #5 clk = ~clk;

    // One-cycle core stand-in: disparity is a fixed function of the pixel pair.
    always @(posedge clk) begin
        if (core_rst) begin
            core_valid_out <= 1'b0;
            core_disparity <= 6'd0;
        end else begin
            core_valid_out <= core_pixel_valid;
            core_disparity <= core_left[5:0] ^ core_right[5:0];
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [25:0] got_q[$];
    int got_cyc[$];
    int acc_cyc[$];
    beat_t beats_q[$];
    int done_n, done_cyc, fwd_n, crst_n;

    always @(negedge clk) begin
        if (out_valid) begin
            got_q.push_back({out_disparity, out_x, out_y, out_sof, out_eol});
            got_cyc.push_back(cyc);
        end
        if (done) begin done_n++; done_cyc = cyc; end
        if (core_pixel_valid) fwd_n++;
        if (core_rst && !rst) crst_n++;
    end

    int checks = 0, failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: frame-level rules applied to the list of offered beats.
    logic [25:0] exp_q[$];
    int exp_frames, exp_fwd;
    bit exp_err;

    task automatic run_model();
        int phase, p, x, y;
        logic bad;
        phase = 0; p = 0;
        exp_q.delete(); exp_frames = 0; exp_fwd = 0; exp_err = 0;
        foreach (beats_q[i]) begin
            if (phase == 2) continue;
            if (phase == 0 && !beats_q[i].sof) continue;
            x = p % W; y = p / W;
            bad = (beats_q[i].eol != (x == W - 1)) || (phase == 1 && beats_q[i].sof);
            if (bad) begin exp_err = 1; phase = 0; p = 0; continue; end
            exp_q.push_back({beats_q[i].l[5:0] ^ beats_q[i].r[5:0], 9'(x), 9'(y), p == 0, x == W - 1});
            exp_fwd++; p++; phase = 1;
            if (p == W * H) begin exp_frames++; p = 0; phase = AUTO ? 0 : 2; end
        end
    endtask

    task automatic clear_mon();
        got_q.delete(); got_cyc.delete(); acc_cyc.delete(); beats_q.delete();
        done_n = 0; fwd_n = 0; crst_n = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; start = 1'b0; sif.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        clear_mon();
        rst = 1'b0;
    endtask

    task automatic start_pulse();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic send_beat(input beat_t b, input bit hs, input int gap);
        int n;
        sif.in_valid = 1'b1; sif.in_left = b.l; sif.in_right = b.r;
        sif.in_sof = b.sof; sif.in_eol = b.eol;
        if (hs) begin
            n = 0;
            while (!sif.in_ready && n < 50) begin @(negedge clk); n++; end
            if (n >= 50) chk("handshake_timeout", 32'd0, 32'd1);
            else acc_cyc.push_back(cyc);
        end else begin
            chk("in_ready_idle", 32'(sif.in_ready), 32'd0);
        end
        beats_q.push_back(b);
        @(negedge clk);
        sif.in_valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_frame(input int bad_idx, input bit hs, input int gap);
        beat_t b;
        for (int i = 0; i < W * H; i++) begin
            b.l = 8'($urandom); b.r = 8'($urandom);
            b.sof = (i == 0); b.eol = (i % W == W - 1);
            if (i == bad_idx) b.eol = ~b.eol;
            send_beat(b, hs, gap);
        end
    endtask

    task automatic check_all(input string tag);
        run_model();
        repeat (20) @(negedge clk);
        chk({tag, "_nout"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            chk($sformatf("%s_out%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
        chk({tag, "_done_n"}, 32'(done_n), 32'(exp_frames));
        chk({tag, "_frame_count"}, 32'(frame_count), 32'(exp_frames));
        chk({tag, "_err_sync"}, 32'(err_sync), 32'(exp_err));
        chk({tag, "_fwd_n"}, 32'(fwd_n), 32'(exp_fwd));
    endtask

    task automatic check_latency(input string tag);
        for (int i = 0; i < acc_cyc.size() && i < got_cyc.size(); i++)
            chk($sformatf("%s_lat%0d", tag, i), 32'(got_cyc[i] - acc_cyc[i]), 32'd3);
        if (got_cyc.size() > 0)
            chk({tag, "_done_timing"}, 32'(done_cyc), 32'(got_cyc[got_cyc.size() - 1] + 1));
    endtask

    initial begin
        beat_t b;
        sif.in_valid = 1'b0; sif.in_left = '0; sif.in_right = '0; sif.in_sof = 1'b0; sif.in_eol = 1'b0;
        clear_mon();

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(sif.in_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_core_pv", 32'(core_pixel_valid), 32'd0);
        chk("rst_out_valid", 32'({out_valid, out_sof, out_eol}), 32'd0);
        chk("rst_out_data", 32'({out_disparity, out_x, out_y}), 32'd0);
        chk("rst_err", 32'(err_sync), 32'd0);
        chk("rst_frame_count", 32'(frame_count), 32'd0);
        chk("rst_core_rst", 32'(core_rst), 32'd1);
        chk("rst_core_pix", 32'({core_left, core_right}), 32'd0);

        // Start coincident with reset is ignored
        start = 1'b1; @(negedge clk); start = 1'b0; rst = 1'b0; @(negedge clk);
        chk("start_in_rst_busy", 32'(busy), 32'd0);

        // Clean frame
        do_reset(); start_pulse();
        @(negedge clk);
        chk("busy_after_start", 32'(busy), 32'd1);
        send_frame(-1, 1'b1, 0);
        check_all("clean");
        check_latency("clean");
        chk("clean_idle_busy", 32'(busy), 32'd0);
        chk("clean_core_rst_pulses", 32'(crst_n), 32'd1);

        // Leading garbage
        do_reset(); start_pulse();
        for (int i = 0; i < 5; i++) begin
            b.l = 8'($urandom); b.r = 8'($urandom); b.sof = 1'b0; b.eol = 1'($urandom);
            send_beat(b, 1'b1, 0);
        end
        chk("garbage_core_pv", 32'(fwd_n), 32'd0);
        send_frame(-1, 1'b1, 0);
        check_all("garbage");

        // Short line: EOL at x=2 on line 1, then a correct frame
        do_reset(); start_pulse();
        send_frame(W + 2, 1'b1, 0);
        send_frame(-1, 1'b1, 0);
        check_all("shortline");
        chk("shortline_core_rst_pulses", 32'(crst_n), 32'd2);

        // Gapped input 1010...
        do_reset(); start_pulse();
        send_frame(-1, 1'b1, 1);
        check_all("gapped");
        check_latency("gapped");

        // Error on the final pixel
        do_reset(); start_pulse();
        send_frame(W * H - 1, 1'b1, 0);
        check_all("lastbad");
        chk("lastbad_busy", 32'(busy), 32'd1);

        // Reset mid-frame
        do_reset(); start_pulse();
        for (int i = 0; i < 6; i++) begin
            b.l = 8'($urandom); b.r = 8'($urandom); b.sof = (i == 0); b.eol = (i % W == W - 1);
            send_beat(b, 1'b1, 0);
        end
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_outs", 32'({busy, done, sif.in_ready, core_pixel_valid, out_valid, err_sync}), 32'd0);
        chk("midrst_frame_count", 32'(frame_count), 32'd0);
        chk("midrst_core_rst", 32'(core_rst), 32'd1);
        chk("midrst_no_done", 32'(done_n), 32'd0);
        clear_mon();
        rst = 1'b0;
        start_pulse();
        send_frame(-1, 1'b1, 0);
        check_all("midrst");

        // Back-to-back frames without a second start
        do_reset(); start_pulse();
        send_frame(-1, 1'b1, 0);
        repeat (8) @(negedge clk);
        send_frame(-1, AUTO, 0);
        check_all("b2b");
        chk("b2b_frame_count", 32'(frame_count), AUTO ? 32'd2 : 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sgm_frame_sequencer.md
# sgm_frame_sequencer

Frame-level controller that sits between the stereo camera stream and the 2-path SGM core. It sequences each frame: it resets the core, aligns to start-of-frame, gates and registers pixels into the core, and checks line and frame framing. It also tags the core's disparity stream with x/y coordinates and SOF/EOL markers, and drains the pipeline before signalling completion.

## Interface
- FRAME_WIDTH, 272, pixels per line; must match the core.
- FRAME_HEIGHT, 240, lines per frame; must match the core.
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  one-cycle pulse that begins a frame; ignored unless the FSM is in IDLE.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the last disparity of a frame has been output.
- in_valid  in  1  input beat valid.
- in_ready  out  1  sequencer accepts the beat; transfer = in_valid & in_ready.
- in_left, in_right  in  8 each  stereo pixel pair.
- in_sof  in  1  beat is pixel (0,0).
- in_eol  in  1  beat is the last pixel of a line.
- core_rst  out  1  reset to the SGM core.
- core_left, core_right  out  8 each  registered pixels to the core.
- core_pixel_valid  out  1  registered qualifier to the core.
- core_disparity  in  6  core result.
- core_valid_out  in  1  core result qualifier.
- out_valid  out  1  tagged disparity valid.
- out_disparity  out  6  disparity value.
- out_x, out_y  out  9 each  coordinate of out_disparity.
- out_sof, out_eol  out  1 each  markers aligned with out_valid.
- err_sync  out  1  sticky framing-error flag; cleared only by rst.
- frame_count  out  16  completed frames; wraps from 0xFFFF to 0.

## Operation
- FSM states: IDLE, CLEAR, WAIT_SOF, STREAM, DRAIN, DONE.
- IDLE: in_ready=0. A start pulse moves the FSM to CLEAR.
- CLEAR: lasts exactly 1 cycle.
  - core_rst=1.
  - Input counters and output counters are zeroed.
  - Next state is WAIT_SOF.
- WAIT_SOF: in_ready=1.
  - Accepted beats with in_sof=0 are consumed and discarded.
  - An accepted beat with in_sof=1 is forwarded as pixel (0,0), and the FSM moves to STREAM.
- STREAM: in_ready=1. Each accepted beat is forwarded, and in_x/in_y advance with a wrap at FRAME_WIDTH-1.
- Framing check on every accepted STREAM beat:
  - in_eol must equal (in_x==FRAME_WIDTH-1).
  - in_sof must be 0.
  - The SOF beat is checked for in_eol in the same way.
- Framing error handling:
  - The offending beat is not forwarded.
  - err_sync is set.
  - The FSM moves to CLEAR, which resynchronises on the next SOF. Partial-frame outputs already emitted are not retracted, and done is not pulsed.
- After the beat at (FRAME_WIDTH-1, FRAME_HEIGHT-1) is forwarded, the FSM moves to DRAIN.
- DRAIN: in_ready=0. Waits until out_x/out_y have counted FRAME_WIDTH*FRAME_HEIGHT core results, then moves to DONE.
- DONE: lasts 1 cycle. done=1 and frame_count increments. The next state depends on the macro described under Configuration.
- core_rst = rst | (state==CLEAR).
- Output tagging:
  - Each core_valid_out produces one out_valid with the current out_x/out_y; then the output counters advance.
  - out_sof = (out_x==0 && out_y==0).
  - out_eol = (out_x==FRAME_WIDTH-1).
- No output back-pressure. The downstream consumer must accept every beat.

## Timing
- Reset values:
  - in_ready, busy, done, core_pixel_valid, out_valid, out_sof, out_eol, err_sync = 0.
  - All data outputs, counters and frame_count = 0.
  - state = IDLE.
  - core_rst = 1 while rst is high.
- Latency from input to core: an accepted beat appears on core_* on the next cycle (registered).
- Latency from core to output: out_* is registered from core_valid_out, adding 1 cycle.
  - The core adds 1 cycle.
  - Total latency from accepted beat to out_valid is 3 cycles.
- in_ready is combinational from state only; it does not depend on in_valid.
- start arriving in the same cycle as rst is ignored.
- start while busy is ignored.
- rst asserted mid-frame aborts immediately: no done, and frame_count is unchanged.
- A framing error on the final pixel is handled as an error; the FSM does not go to DRAIN.
- Idle cycles (in_valid=0) during STREAM are legal and produce core_pixel_valid=0.

## Configuration
- SGM_SEQ_AUTO_RESTART_EN defined: DONE moves directly to CLEAR, giving continuous frame processing without start pulses. busy stays high between frames.
- SGM_SEQ_AUTO_RESTART_EN undefined: DONE returns to IDLE, and each frame requires a start pulse.

## Test plan
All tests use FRAME_WIDTH=4 and FRAME_HEIGHT=3 unless stated.
- Clean frame: start, then 12 beats with correct SOF/EOL.
  - Required: 12 out_valid with coordinates (0,0)..(3,2).
  - out_eol at x=3; out_sof once.
  - done pulses 1 cycle after the last out_valid; frame_count=1; err_sync=0.
- Leading garbage: 5 beats with in_sof=0 before the SOF.
  - Required: the 5 beats are discarded, core_pixel_valid stays 0 for them, and the frame completes normally.
- Short line: in_eol asserted at x=2 on line 1.
  - Required: err_sync=1, core_rst pulses 1 cycle, the offending beat is not forwarded.
  - The next correct frame then completes with done and frame_count=1.
- Gapped input: in_valid toggling 1010…
  - Required: output values identical to the clean case; the 3-cycle latency holds per beat.
- Reset mid-frame: rst asserted after 6 beats.
  - Required: all outputs return to reset values and no done pulse occurs.
  - A later start with a full frame gives frame_count=1.
- Back-to-back frames: two frames sent without start pulses.
  - With the macro: frame_count reaches 2.
  - Without the macro: the second SOF is ignored, in_ready=0 in IDLE, and frame_count=1.
